// File: rtl/mips_lsu_bus_master.sv
// rtl/mips_lsu_bus_master.sv - MIPS load/store unit driving a word-wide byte-enabled memory bus
module mips_lsu_bus_master #(
   parameter int ADDR_W      = 32,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE, S_ERR} state_t;

   state_t      state, state_nx;
   logic [3:0]  op_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic [31:0] result_q;

   logic        is_legal, is_half, is_word, misaligned, go_err;
   logic [1:0]  off_eff;
   logic [3:0]  be_nx;
   logic [31:0] wd_nx;
   logic [31:0] load_res;

   // Request decode; with alignment checking off the offending low bits are dropped.
   always_comb begin
      is_legal = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (req_op)
         4'd0, 4'd4, 4'd8:  is_legal = 1'b1;
         4'd1, 4'd5, 4'd9:  begin is_legal = 1'b1; is_half = 1'b1; end
         4'd3, 4'd11:       begin is_legal = 1'b1; is_word = 1'b1; end
         4'd2, 4'd6:        is_legal = 1'b1;
         default:           is_legal = 1'b0;
      endcase
      misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
      go_err     = !is_legal || (CHECK_ALIGN && misaligned);

      off_eff = req_addr[1:0];
      if (is_half) off_eff[0] = 1'b0;
      if (is_word) off_eff    = 2'b00;

      case (req_op[2:0])
         3'd0, 3'd4: be_nx = 4'b0001 << off_eff;
         3'd1, 3'd5: be_nx = 4'b0011 << off_eff;
         3'd2: begin
            case (off_eff)
               2'd0:    be_nx = 4'b0001;
               2'd1:    be_nx = 4'b0011;
               2'd2:    be_nx = 4'b0111;
               default: be_nx = 4'b1111;
            endcase
         end
         3'd3:       be_nx = 4'b1111;
         3'd6:       be_nx = 4'b1111 << off_eff;
         default:    be_nx = 4'b0000;
      endcase

      case (req_op)
         4'd8:    wd_nx = {4{req_wdata[7:0]}};
         4'd9:    wd_nx = {2{req_wdata[15:0]}};
         4'd11:   wd_nx = req_wdata;
         default: wd_nx = 32'd0;
      endcase
   end

   logic [4:0]  sh;
   logic [31:0] rd_shr;

   always_comb begin
      sh       = {off_q, 3'b000};
      rd_shr   = avm_readdata >> sh;
      load_res = 32'd0;
      case (op_q)
         4'd0:    load_res = {{24{rd_shr[7]}}, rd_shr[7:0]};
         4'd4:    load_res = {24'd0, rd_shr[7:0]};
         4'd1:    load_res = {{16{rd_shr[15]}}, rd_shr[15:0]};
         4'd5:    load_res = {16'd0, rd_shr[15:0]};
         4'd3:    load_res = avm_readdata;
         // Unaligned merges: memory bytes land in the high (LWL) or low (LWR) end of rt.
         4'd2:    load_res = (avm_readdata << (5'd24 - sh)) |
                             (wdata_q & ((32'd1 << (5'd24 - sh)) - 32'd1));
         4'd6:    load_res = rd_shr | (wdata_q & ~(32'hFFFF_FFFF >> sh));
         default: load_res = 32'd0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (req_valid) state_nx = go_err ? S_ERR : S_ISSUE;
         S_ISSUE:   if (!avm_waitrequest) state_nx = op_q[3] ? S_DONE : S_CAPTURE;
         S_CAPTURE: state_nx = S_DONE;
         S_DONE:    state_nx = S_IDLE;
         S_ERR:     state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         op_q           <= 4'd0;
         off_q          <= 2'd0;
         wdata_q        <= 32'd0;
         result_q       <= 32'd0;
         avm_address    <= '0;
         avm_byteenable <= 4'd0;
         avm_writedata  <= 32'd0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && req_valid) begin
            op_q     <= req_op;
            off_q    <= off_eff;
            wdata_q  <= req_wdata;
            result_q <= 32'd0;
            if (!go_err) begin
               avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
               avm_byteenable <= be_nx;
               avm_writedata  <= wd_nx;
            end
         end
         if (state == S_CAPTURE) result_q <= load_res;
      end
   end

   assign req_ready  = (state == S_IDLE);
   assign avm_read   = (state == S_ISSUE) && !op_q[3];
   assign avm_write  = (state == S_ISSUE) &&  op_q[3];
   assign resp_valid = (state == S_DONE) || (state == S_ERR);
   assign resp_err   = (state == S_ERR);
   assign resp_data  = (state == S_DONE) ? result_q : 32'd0;

endmodule

// File: tb/tb_mips_lsu_bus_master.sv
// tb/tb_mips_lsu_bus_master.sv - randomized bench with byte-level reference model for mips_lsu_bus_master
module tb_mips_lsu_bus_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [31:0] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   mips_lsu_bus_master #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Responder RAM (written only by the DUT) and the model's view of memory.
   logic [31:0] ram     [64];
   logic [31:0] ref_mem [64];
   int          nwait_cfg = 0;
   int          wait_cnt  = 0;

   assign avm_waitrequest = (wait_cnt < nwait_cfg);

   always @(posedge clk) begin
      avm_readdata <= $urandom;
      if (avm_read || avm_write) begin
         if (wait_cnt < nwait_cfg) wait_cnt <= wait_cnt + 1;
         else begin
            wait_cnt <= 0;
            if (avm_read) avm_readdata <= ram[avm_address[7:2]];
            for (int i = 0; i < 4; i++)
               if (avm_write && avm_byteenable[i])
                  ram[avm_address[7:2]][8*i +: 8] = avm_writedata[8*i +: 8];
         end
      end else wait_cnt <= 0;
   end

   logic        m_err, m_store;
   logic [3:0]  m_be;
   logic [31:0] m_wd, m_res, m_addr;
   int          m_rk, m_nwait;

   task automatic model_txn(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] rt, input int nw);
      int         o, sz;
      bit         legal;
      logic [7:0] mb[4], rb[4], r[4];
      logic [31:0] w;
      o = int'(a[1:0]);
      w = ref_mem[a[7:2]];
      legal = 1; sz = 0;
      case (op)
         4'd0, 4'd4, 4'd8: sz = 1;
         4'd1, 4'd5, 4'd9: sz = 2;
         4'd3, 4'd11:      sz = 4;
         4'd2, 4'd6:       sz = 0;
         default:          legal = 0;
      endcase
      m_err   = !legal || (sz == 2 && o % 2 == 1) || (sz == 4 && o != 0);
      m_store = op[3];
      m_nwait = nw;
      m_addr  = {a[31:2], 2'b00};
      m_rk    = m_err ? 1 : (m_store ? 2 + nw : 3 + nw);
      for (int i = 0; i < 4; i++) begin
         mb[i] = w[8*i +: 8];
         rb[i] = rt[8*i +: 8];
         r[i]  = 8'd0;
      end
      m_be = 4'd0; m_wd = 32'd0; m_res = 32'd0;
      if (!m_err) begin
         for (int i = 0; i < 4; i++) begin
            case (op[2:0])
               3'd0, 3'd4: m_be[i] = (i == o);
               3'd1, 3'd5: m_be[i] = (i == o) || (i == o + 1);
               3'd3:       m_be[i] = 1'b1;
               3'd2:       m_be[i] = (i <= o);
               3'd6:       m_be[i] = (i >= o);
               default:    m_be[i] = 1'b0;
            endcase
            if (m_store && m_be[i]) begin
               m_wd[8*i +: 8] = (sz == 1) ? rb[0] : (sz == 2) ? rb[i-o] : rb[i];
               ref_mem[a[7:2]][8*i +: 8] = m_wd[8*i +: 8];
            end
         end
         case (op)
            4'd0: m_res = {{24{mb[o][7]}}, mb[o]};
            4'd4: m_res = {24'd0, mb[o]};
            4'd1: m_res = {{16{mb[o+1][7]}}, mb[o+1], mb[o]};
            4'd5: m_res = {16'd0, mb[o+1], mb[o]};
            4'd3: m_res = w;
            4'd2: begin
               for (int i = 0; i < 4; i++) r[i] = (i >= 3 - o) ? mb[i-(3-o)] : rb[i];
               m_res = {r[3], r[2], r[1], r[0]};
            end
            4'd6: begin
               for (int i = 0; i < 4; i++) r[i] = (i <= 3 - o) ? mb[o+i] : rb[i];
               m_res = {r[3], r[2], r[1], r[0]};
            end
            default: m_res = 32'd0;
         endcase
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{be[i]}};
   endfunction

   bit          busy   = 0;
   bit          manual = 0;
   int          k      = 0;
   int          resp_count = 0;
   logic [3:0]  last_be;
   logic [31:0] last_addr, last_wd, last_data;
   logic        last_err;

   always @(negedge clk) begin
      bit se;
      if (busy) begin
         k++;
         se = !m_err && (k <= 1 + m_nwait);
         chk("avm_read", avm_read, se && !m_store);
         chk("avm_write", avm_write, se && m_store);
         chk("req_ready_busy", req_ready, 1'b0);
         if (se) begin
            chk("avm_address", avm_address, m_addr);
            chk("avm_byteenable", avm_byteenable, m_be);
            if (m_store) chk("avm_writedata", avm_writedata & lane_mask(m_be), m_wd);
            last_be   = avm_byteenable;
            last_addr = avm_address;
            last_wd   = avm_writedata;
         end
         chk("resp_valid", resp_valid, k == m_rk);
         if (k == m_rk) begin
            chk("resp_data", resp_data, m_res);
            chk("resp_err", resp_err, m_err);
            last_data = resp_data;
            last_err  = resp_err;
            resp_count++;
         end
      end else begin
         k = 0;
         if (!manual && !reset) begin
            chk("idle_ready", req_ready, 1'b1);
            chk("idle_resp", resp_valid, 1'b0);
            chk("idle_strobe", avm_read | avm_write, 1'b0);
         end
      end
   end

   task automatic run(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] rt, input int nw);
      int t, start;
      @(negedge clk);
      nwait_cfg = nw;
      model_txn(op, a, rt, nw);
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = rt;
      @(posedge clk); #1;
      busy  = 1;
      start = resp_count;
      req_valid = 1'($urandom); req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
      t = 0;
      while (resp_count == start && t < 40) begin
         @(negedge clk); #1;
         t++;
      end
      req_valid = 1'b0;
      if (resp_count == start) begin
         checks++; errors++;
         $display("FAIL response_timeout: got none expected resp after %0d cycles (op %0d)", m_rk, op);
      end
      busy = 0;
   endtask

   initial begin
      logic [31:0] w, a;
      logic [3:0]  op;
      logic [3:0]  ops [16];
      reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
      for (int i = 0; i < 64; i++) begin
         w = $urandom; ram[i] = w; ref_mem[i] = w;
      end
      ram[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
      ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_read_write", {avm_read, avm_write}, 2'b00);
      chk("rst_address", avm_address, 32'd0);
      chk("rst_byteenable", avm_byteenable, 4'd0);
      chk("rst_writedata", avm_writedata, 32'd0);
      @(negedge clk); reset = 1'b0;

      run(4'd0, 32'h11, $urandom, 0);
      chk("lb_data", last_data, 32'hFFFFFFAA);
      chk("lb_be", last_be, 4'b0010);
      chk("lb_addr", last_addr, 32'h10);
      run(4'd4, 32'h13, $urandom, 0);
      chk("lbu_data", last_data, 32'h00000088);
      run(4'd1, 32'h12, $urandom, 0);
      chk("lh_data", last_data, 32'hFFFF8899);
      run(4'd8, 32'h22, 32'h123456CD, 0);
      chk("sb_be", last_be, 4'b0100);
      chk("sb_lane2", last_wd[23:16], 8'hCD);
      run(4'd3, 32'h20, $urandom, 0);
      chk("sb_then_lw", last_data, 32'h11CD3344);
      run(4'd2, 32'h11, 32'hDEADBEEF, 0);
      chk("lwl_be", last_be, 4'b0011);
      chk("lwl_data", last_data, 32'hAABBBEEF);
      run(4'd6, 32'h12, 32'hDEADBEEF, 0);
      chk("lwr_be", last_be, 4'b1100);
      chk("lwr_data", last_data, 32'hDEAD8899);
      run(4'd3, 32'h10, $urandom, 3);
      chk("lw_wait_data", last_data, 32'h8899AABB);
      run(4'd1, 32'h01, $urandom, 0);
      chk("lh_misalign_err", last_err, 1'b1);
      chk("lh_misalign_data", last_data, 32'd0);
      run(4'd7, 32'h10, $urandom, 0);
      chk("illegal_op_err", last_err, 1'b1);

      // Reset while a read is stalled on the bus.
      manual = 1;
      @(negedge clk);
      nwait_cfg = 100;
      req_valid = 1'b1; req_op = 4'd3; req_addr = 32'h10;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("stall_read_on", avm_read, 1'b1);
      @(negedge clk); #2 reset = 1'b1;
      #1;
      chk("rst_mid_strobes", {avm_read, avm_write}, 2'b00);
      chk("rst_mid_ready", req_ready, 1'b1);
      chk("rst_mid_resp", resp_valid, 1'b0);
      @(negedge clk); reset = 1'b0; nwait_cfg = 0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_resp", resp_valid, 1'b0);
         chk("post_rst_read", avm_read, 1'b0);
      end
      manual = 0;
      run(4'd11, 32'h30, 32'hCAFEF00D, 0);
      run(4'd3, 32'h30, $urandom, 0);
      chk("sw_after_reset", last_data, 32'hCAFEF00D);

      for (int i = 0; i < 16; i++) ops[i] = 4'(i);
      repeat (400) begin
         op = ops[$urandom_range(0, 15)];
         a  = $urandom;
         if ($urandom_range(0, 1) == 1 && (op == 4'd3 || op == 4'd11)) a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1 && (op == 4'd1 || op == 4'd5 || op == 4'd9)) a[0] = 1'b0;
         run(op, a, $urandom, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
